// File: rtl/onehot_decoder_pipe.sv
// Pipelined 3-to-8 one-hot decoder with a 2-entry elastic buffer, a
// self-generated walking-one sweep mode and a saturating delivered-word counter.
module onehot_decoder_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_code,
    input  logic             in_en,
    input  logic             start_sweep,
    output logic             sweep_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_y,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic ST_NORMAL = 1'b0;
    localparam logic ST_SWEEP  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             state_reg;
    logic [1:0]       count_reg;
    logic [3:0]       entry0_reg;   // head slot: {en, code}
    logic [3:0]       entry1_reg;
    logic [2:0]       sweep_pos_reg;
    logic [CNT_W-1:0] word_cnt_reg;

    logic       push_norm;
    logic       push_sweep;
    logic       push;
    logic       pop;
    logic [3:0] push_data;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready   = (state_reg == ST_NORMAL) && (count_reg != 2'd2);
    assign push_norm  = in_valid && in_ready;
    assign push_sweep = (state_reg == ST_SWEEP) && (count_reg != 2'd2);
    assign push       = push_norm || push_sweep;
    assign push_data  = push_sweep ? {1'b1, sweep_pos_reg} : {in_en, in_code};
    assign out_valid  = (count_reg != 2'd0);
    assign pop        = out_valid && out_ready;
    assign sweep_busy = (state_reg == ST_SWEEP);
    assign word_cnt   = word_cnt_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign out_y[gi] = out_valid && entry0_reg[3] && (entry0_reg[2:0] == 3'(gi));
        end
    endgenerate

    // Head always lives in entry0; a pop shifts entry1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            entry0_reg <= 4'd0;
            entry1_reg <= 4'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_reg == 2'd0)
                        entry0_reg <= push_data;
                    else
                        entry1_reg <= push_data;
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    entry0_reg <= entry1_reg;
                    count_reg  <= count_reg - 2'd1;
                end
                // Push with pop only happens at count 1: new word becomes head.
                2'b11: entry0_reg <= push_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_NORMAL;
            sweep_pos_reg <= 3'd0;
        end else if (state_reg == ST_NORMAL) begin
            if (start_sweep && (count_reg == 2'd0) && !in_valid) begin
                state_reg     <= ST_SWEEP;
                sweep_pos_reg <= 3'd0;
            end
        end else if (push_sweep) begin
            if (sweep_pos_reg == 3'd7) begin
                state_reg     <= ST_NORMAL;
                sweep_pos_reg <= 3'd0;
            end else begin
                sweep_pos_reg <= sweep_pos_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            word_cnt_reg <= '0;
        else if (cnt_clr)
            word_cnt_reg <= '0;
        else if (pop && (word_cnt_reg != CNT_MAX))
            word_cnt_reg <= word_cnt_reg + 1'b1;
    end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed bench for onehot_decoder_pipe: decode, disable, backpressure,
// sweep mode, asynchronous reset mid-sweep and counter saturation/clear.
module tb_onehot_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_en;
    logic       start_sweep;
    logic       sweep_busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       cnt_clr;
    logic [3:0] word_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    onehot_decoder_pipe #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_code     (in_code),
        .in_en       (in_en),
        .start_sweep (start_sweep),
        .sweep_busy  (sweep_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .cnt_clr     (cnt_clr),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        int exp_idx;
        int n;
        int hs;
        logic       prev_stall;
        logic [7:0] prev_y;

        rst_n = 1'b0; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0;
        start_sweep = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'h00);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic decode, one word per cycle with a free-running sink.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_en = 1'b1; in_code = 3'(i);
            chk("dec_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("dec_out_valid", 32'(out_valid), 32'd1);
            chk($sformatf("dec_y%0d", i), 32'(out_y), 32'(onehot_tbl[i]));
        end
        in_valid = 1'b0;
        tick();
        chk("dec_drained", 32'(out_valid), 32'd0);
        chk("dec_word_cnt", 32'(word_cnt), 32'd8);

        // Disabled decode yields a zero word that still counts.
        clr_cnt();
        in_valid = 1'b1; in_en = 1'b0; in_code = 3'd5;
        tick();
        in_valid = 1'b0;
        chk("dis_out_valid", 32'(out_valid), 32'd1);
        chk("dis_out_y", 32'(out_y), 32'h00);
        tick();
        chk("dis_word_cnt", 32'(word_cnt), 32'd1);

        // Backpressure: third word waits until space frees up.
        clr_cnt();
        out_ready = 1'b0; in_en = 1'b1;
        in_valid = 1'b1; in_code = 3'd3;
        tick();
        in_code = 3'd6;
        tick();
        in_code = 3'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_y", 32'(out_y), 32'h08);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_first_y", 32'(out_y), 32'h08);
        tick();
        chk("bp_second_y", 32'(out_y), 32'h40);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_third_y", 32'(out_y), 32'h02);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_word_cnt", 32'(word_cnt), 32'd3);

        // start_sweep with one word buffered must be ignored.
        out_ready = 1'b0;
        in_valid = 1'b1; in_en = 1'b1; in_code = 3'd2;
        tick();
        in_valid = 1'b0;
        start_sweep = 1'b1;
        tick();
        start_sweep = 1'b0;
        chk("sw_ignored", 32'(sweep_busy), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("sw_pre_drained", 32'(out_valid), 32'd0);

        // Sweep with random stalls on the sink.
        start_sweep = 1'b1;
        tick();
        start_sweep = 1'b0;
        chk("sw_busy", 32'(sweep_busy), 32'd1);
        chk("sw_in_ready", 32'(in_ready), 32'd0);
        exp_idx = 0; n = 0; prev_stall = 1'b0; prev_y = 8'h00;
        while (exp_idx < 8 && n < 200) begin
            if (prev_stall)
                chk("sw_hold", 32'(out_y), 32'(prev_y));
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                chk($sformatf("sw_y%0d", exp_idx), 32'(out_y), 32'(onehot_tbl[exp_idx]));
                exp_idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y = out_y;
            tick();
            n++;
        end
        if (exp_idx < 8)
            chk("sw_timeout", 32'(exp_idx), 32'd8);
        out_ready = 1'b1;
        chk("sw_busy_clear", 32'(sweep_busy), 32'd0);
        chk("sw_done_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset after three sweep outputs.
        clr_cnt();
        start_sweep = 1'b1;
        tick();
        start_sweep = 1'b0;
        hs = 0; n = 0;
        while (hs < 3 && n < 50) begin
            if (out_valid) hs++;
            tick();
            n++;
        end
        chk("ar_pre_cnt", 32'(word_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_y", 32'(out_y), 32'h00);
        chk("ar_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("ar_word_cnt", 32'(word_cnt), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        start_sweep = 1'b1;
        tick();
        start_sweep = 1'b0;
        tick();
        chk("ar_restart_y", 32'(out_y), 32'h01);
        for (int i = 0; i < 9; i++) tick();
        chk("ar_restart_done", 32'(sweep_busy), 32'd0);

        // Counter saturation at 15, then clear beating a handshake.
        clr_cnt();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_en = 1'b1; in_code = 3'(i % 8);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_saturate", 32'(word_cnt), 32'd15);
        in_valid = 1'b1; in_code = 3'd4;
        tick();
        in_valid = 1'b0;
        chk("cnt_hs_pending", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_prio", 32'(word_cnt), 32'd0);
        chk("cnt_popped", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_pipe.md
ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the delivered-word counter (legal range 4..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  in_code/in_en hold a word to decode.
REQ-005 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port: in_code  input  3  binary code, 0..7.
REQ-007 SHALL have port: in_en  input  1  decode enable; 0 means the output word is all zeros.
REQ-008 SHALL have port: start_sweep  input  1  single-cycle request for a self-generated walking-one sequence.
REQ-009 SHALL have port: sweep_busy  output  1  high while in the SWEEP state.
REQ-010 SHALL have port: out_valid  output  1  out_y holds a decoded word.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts out_y this cycle.
REQ-012 SHALL have port: out_y  output  8  one-hot decoded word.
REQ-013 SHALL have port: cnt_clr  input  1  synchronous clear of word_cnt.
REQ-014 SHALL have port: word_cnt  output  CNT_W  count of delivered words.

Function
REQ-015 SHALL accept an input word on each rising edge where in_valid=1 and in_ready=1, and SHALL NOT accept one otherwise.
REQ-016 SHALL store each accepted {in_en, in_code} in a 2-entry in-order FIFO.
REQ-017 SHALL drive out_valid=1 exactly when the FIFO is non-empty, with out_y decoded from the head entry.
REQ-018 SHALL set out_y = 8'h01 << code when the head en=1, 8'h00 when en=0, and 8'h00 whenever out_valid=0.
REQ-019 SHALL remove the head on each edge where out_valid=1 and out_ready=1.
REQ-020 SHALL drive out_valid high and present the word on the first edge after acceptance; there is no combinational input-to-output path.
REQ-021 SHALL hold out_y and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL drive in_ready = (state==NORMAL) and (FIFO count < 2); in_ready SHALL have no combinational dependence on out_ready.
  - Count 2: no push, even if a pop occurs in the same cycle.
  - Count 1 with simultaneous push and pop: count stays 1 and order is preserved.
REQ-023 SHALL implement the states NORMAL (reset state) and SWEEP.
REQ-024 SHALL move from NORMAL to SWEEP when start_sweep=1, FIFO count=0 and in_valid=0; start_sweep SHALL be ignored under any other condition, including while in SWEEP.
REQ-025 SHALL behave as follows in SWEEP:
  - Push internally generated entries with en=1 and codes 0,1,...,7, in that order, one per cycle while count < 2.
  - Stall the code sequence while the FIFO is full.
  - Return to NORMAL on the edge that pushes code 7.
REQ-026 SHALL drive sweep_busy = (state==SWEEP).
REQ-027 SHALL increment word_cnt by 1 on each output handshake, saturating at 2^CNT_W-1.
REQ-028 SHALL zero word_cnt on cnt_clr=1, with cnt_clr taking priority over a same-cycle increment.

Reset
REQ-029 SHALL, while rst_n=0, immediately force: FIFO empty, state NORMAL, sweep sequence position 0, out_valid=0, out_y=8'h00, sweep_busy=0, word_cnt=0.
REQ-030 SHALL abort any sweep in progress and discard all buffered words when reset is asserted mid-operation.
REQ-031 SHALL present in_ready=1 on the first cycle after rst_n deasserts.

Verification
REQ-032 SHALL verify the basic decode: out_ready=1, push codes 0..7 with en=1 on consecutive cycles -> out_y = 01,02,04,...,80, each one cycle after acceptance; word_cnt=8.
REQ-033 SHALL verify the disable case: push code 5 with en=0 -> out_valid=1 and out_y=8'h00; word_cnt increments.
REQ-034 SHALL verify backpressure: out_ready=0, push codes 3,6,1 -> only 3 and 6 accepted, in_ready=0 with out_y=08 held stable; then raise out_ready -> outputs 08 then 40, and code 1 is accepted on the first cycle in_ready returns high.
REQ-035 SHALL verify the sweep: start_sweep pulse while idle -> sweep_busy=1, in_ready=0; outputs 01..80 in order across stalls from random out_ready; sweep_busy clears after code 7 is pushed; a start_sweep while count=1 is ignored.
REQ-036 SHALL verify async reset mid-sweep after 3 outputs -> out_valid=0, sweep_busy=0 and word_cnt=0 with no clock edge; next start_sweep restarts from 01.
REQ-037 SHALL verify counter behaviour: CNT_W=4, deliver 20 words -> word_cnt=15; cnt_clr asserted during a handshake -> word_cnt=0.
